// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and constants for the L2 cache
package l2_cache_pkg;
    localparam int L2_OFFSET_BITS = 4;
    typedef logic [127:0] lc3b_burst;
    typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, RESP} l2_state_t;
endpackage

// File: rtl/l2_cache_array.sv
// l2_cache_array: direct-mapped tag/data/valid/dirty storage with combinational read by index
//  clk_i/rst_ni      clock, async active-low clear of valid/dirty
//  idx_i             set index for read and write
//  line_we_i         write tag_i/data_i and set valid
//  dirty_we_i        write dirty_i into the dirty bit
//  valid_o/dirty_o/tag_o/data_o   contents of set idx_i
module l2_cache_array
    import l2_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 16 - L2_OFFSET_BITS - INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] idx_i,
    input  logic                  line_we_i,
    input  logic [TAG_BITS-1:0]   tag_i,
    input  lc3b_burst             data_i,
    input  logic                  dirty_we_i,
    input  logic                  dirty_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_BITS-1:0]   tag_o,
    output lc3b_burst             data_o
);
    localparam int SETS = 2 ** INDEX_BITS;
    logic [TAG_BITS-1:0] tag_q [SETS];
    lc3b_burst           data_q [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= data_i;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (line_we_i) valid_q[idx_i] <= 1'b1;
            if (dirty_we_i) dirty_q[idx_i] <= dirty_i;
        end
    end
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];
endmodule

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back L2 serving full-line L1 requests, backed by pmem
//  clk/rst_n                      clock, async active-low reset
//  l2_address/l2_read/l2_write/l2_wdata   level-held L1 request
//  l2_resp/l2_rdata               one-cycle completion pulse and read line
//  pmem_address/pmem_read/pmem_write/pmem_wdata   fill/writeback request to memory
//  pmem_resp/pmem_rdata           memory completion pulse and fill line
module l2_cache
    import l2_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] l2_address,
    input  logic        l2_read,
    input  logic        l2_write,
    input  lc3b_burst   l2_wdata,
    output logic        l2_resp,
    output lc3b_burst   l2_rdata,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_burst   pmem_wdata,
    input  logic        pmem_resp,
    input  lc3b_burst   pmem_rdata
);
    localparam int LA_BITS  = 16 - L2_OFFSET_BITS;
    localparam int TAG_BITS = LA_BITS - INDEX_BITS;
    l2_state_t            state_q, state_d;
    logic [LA_BITS-1:0]   addr_q, addr_d;
    logic                 wr_q, wr_d;
    lc3b_burst            wdata_q, wdata_d;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]  req_tag, tag;
    logic                 valid, dirty, hit, take, match;
    logic                 line_we, dirty_we, dirty_in;
    lc3b_burst            line, line_in;
    logic                 unused_offset;
    assign unused_offset = ^l2_address[L2_OFFSET_BITS-1:0];
    assign idx     = addr_q[INDEX_BITS-1:0];
    assign req_tag = addr_q[LA_BITS-1:INDEX_BITS];
    assign hit     = valid && tag == req_tag;
    assign take    = state_q == IDLE && (l2_read || l2_write);
    // A response is only delivered if the requester is still asking for the same thing.
    assign match   = (l2_read || l2_write) && l2_write == wr_q
                     && l2_address[15:L2_OFFSET_BITS] == addr_q;
    l2_cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .idx_i      (idx),
        .line_we_i  (line_we),
        .tag_i      (req_tag),
        .data_i     (line_in),
        .dirty_we_i (dirty_we),
        .dirty_i    (dirty_in),
        .valid_o    (valid),
        .dirty_o    (dirty),
        .tag_o      (tag),
        .data_o     (line)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end
    always_comb begin
        addr_d  = take ? l2_address[15:L2_OFFSET_BITS] : addr_q;
        wr_d    = take ? l2_write : wr_q;
        wdata_d = take ? l2_wdata : wdata_q;
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = take ? CHECK : IDLE;
            CHECK: state_d = hit ? RESP : (valid && dirty) ? WB : wr_q ? RESP : FILL;
            WB:    state_d = pmem_resp ? CHECK : WB;
            FILL:  state_d = pmem_resp ? CHECK : FILL;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        // Writes allocate without a fill once any dirty victim has been written back.
        line_we      = (state_q == CHECK && wr_q && (hit || !(valid && dirty)))
                       || (state_q == FILL && pmem_resp);
        dirty_we     = line_we || (state_q == WB && pmem_resp);
        dirty_in     = state_q == CHECK;
        line_in      = state_q == FILL ? pmem_rdata : wdata_q;
        pmem_read    = state_q == FILL;
        pmem_write   = state_q == WB;
        pmem_address = state_q == WB ? {tag, idx, 4'h0} : state_q == FILL ? {addr_q, 4'h0} : 16'h0;
        pmem_wdata   = state_q == WB ? line : '0;
        l2_rdata     = state_q == RESP ? line : '0;
        l2_resp      = state_q == RESP && match;
    end
endmodule
